ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 36 +++
 rtl/ram_arbiter.sv | 115 +++++++++++
 tb/tb_ram_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Port bundle for the two-port nibble RAM arbiter: requester ports plus the memory-side bus.
// A port asserts reqN with its we/addr/wdata and keeps it high until doneN pulses; gntN marks ownership.
interface ram_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [3:0] addr0;
    logic [3:0] addr1;
    logic [3:0] wdata0;
    logic [3:0] wdata1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [3:0] rdata0;
    logic [3:0] rdata1;
    logic [3:0] mem_address;
    logic       mem_nwrite_enable;
    logic       mem_nread_enable;
    logic [3:0] mem_data_out;
    logic       mem_data_oe;
    logic [3:0] mem_data_in;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_in,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1,
        input  mem_address, mem_nwrite_enable, mem_nread_enable, mem_data_out, mem_data_oe
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_in,
        output gnt0, gnt1, done0, done1, rdata0, rdata1,
        output mem_address, mem_nwrite_enable, mem_nread_enable, mem_data_out, mem_data_oe
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one asynchronous nibble RAM between two ports.
// Each access runs SETUP -> STROBE (STROBE_CYCLES) -> HOLD, followed by one IDLE cycle.
module ram_arbiter #(
    parameter int STROBE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         nrst,
    ram_arbiter_if.slave bus,
    output logic [1:0]   dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(STROBE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       prio_q, prio_d;
    logic       we_q, we_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] wdata_q, wdata_d;
    logic [3:0] rdata0_q, rdata0_d;
    logic [3:0] rdata1_q, rdata1_d;
    logic       winner;
    logic       busy;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        // prio_q names the port that wins a tie; a lone requester always wins.
        winner   = (bus.req0 && bus.req1) ? prio_q : bus.req1;
        busy     = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = SETUP;
                    owner_d = winner;
                    prio_d  = ~winner;
                    we_d    = winner ? bus.we1    : bus.we0;
                    addr_d  = winner ? bus.addr1  : bus.addr0;
                    wdata_d = winner ? bus.wdata1 : bus.wdata0;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 2'd0;
            end
            STROBE: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = HOLD;
                    if (!we_q) begin
                        if (owner_q) rdata1_d = bus.mem_data_in;
                        else         rdata0_d = bus.mem_data_in;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        bus.gnt0              = busy && !owner_q;
        bus.gnt1              = busy && owner_q;
        bus.done0             = (state_q == HOLD) && !owner_q;
        bus.done1             = (state_q == HOLD) && owner_q;
        bus.rdata0            = rdata0_q;
        bus.rdata1            = rdata1_q;
        bus.mem_address       = addr_q;
        bus.mem_data_oe       = busy && we_q;
        bus.mem_data_out      = (busy && we_q) ? wdata_q : 4'd0;
        bus.mem_nwrite_enable = !((state_q == STROBE) && we_q);
        bus.mem_nread_enable  = !((state_q == STROBE) && !we_q);
        dbg_state_o           = state_q;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 4'd0;
            wdata_q  <= 4'd0;
            rdata0_q <= 4'd0;
            rdata1_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with STROBE_CYCLES=1 on a RAM model,
// one with STROBE_CYCLES=3 whose read bus is driven cycle by cycle.
module tb_ram_arbiter;
    logic       clk = 1'b0;
    logic       nrst;
    logic [1:0] a_state;
    logic [1:0] b_state;

    ram_arbiter_if a_if ();
    ram_arbiter_if b_if ();

    ram_arbiter #(.STROBE_CYCLES(1)) dut_a (
        .clk        (clk),
        .nrst       (nrst),
        .bus        (a_if),
        .dbg_state_o(a_state)
    );

    ram_arbiter #(.STROBE_CYCLES(3)) dut_b (
        .clk        (clk),
        .nrst       (nrst),
        .bus        (b_if),
        .dbg_state_o(b_state)
    );

    always #5 clk = ~clk;

    // Asynchronous RAM behind instance A: written while the write strobe is low.
    logic [3:0] mem_a [16];
    always @(posedge clk) begin
        if (!a_if.mem_nwrite_enable && a_if.mem_data_oe)
            mem_a[a_if.mem_address] <= a_if.mem_data_out;
    end
    assign a_if.mem_data_in = mem_a[a_if.mem_address];

    int n_excl = 0;
    int n_oe_rd = 0;
    always @(negedge clk) begin
        if (!a_if.mem_nwrite_enable && !a_if.mem_nread_enable) n_excl++;
        if (!b_if.mem_nwrite_enable && !b_if.mem_nread_enable) n_excl++;
        if (a_if.mem_data_oe && !a_if.mem_nread_enable) n_oe_rd++;
        if (b_if.mem_data_oe && !b_if.mem_nread_enable) n_oe_rd++;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] cnt_gnt, cnt_other, cnt_nwe, cnt_nre, cnt_oe, cnt_done;
    logic [3:0]  st_addr, st_data, hold_rdata;

    task automatic set_req_a(input logic port, input logic v);
        if (port) a_if.req1 = v;
        else      a_if.req0 = v;
    endtask

    // One access on instance A; inputs are scrambled after the grant to prove they were latched.
    task automatic run_a(input logic port, input logic we, input logic [3:0] addr,
                         input logic [3:0] wdata, input logic drop_early);
        cnt_gnt = 0; cnt_other = 0; cnt_nwe = 0; cnt_nre = 0; cnt_oe = 0; cnt_done = 0;
        st_addr = 4'd0; st_data = 4'd0; hold_rdata = 4'd0;
        if (port) begin
            a_if.we1 = we; a_if.addr1 = addr; a_if.wdata1 = wdata;
        end else begin
            a_if.we0 = we; a_if.addr0 = addr; a_if.wdata0 = wdata;
        end
        set_req_a(port, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (port ? a_if.gnt1 : a_if.gnt0) cnt_gnt++;
            if (port ? a_if.gnt0 : a_if.gnt1) cnt_other++;
            if (!a_if.mem_nwrite_enable) begin
                cnt_nwe++;
                st_addr = a_if.mem_address;
                st_data = a_if.mem_data_out;
            end
            if (!a_if.mem_nread_enable) begin
                cnt_nre++;
                st_addr = a_if.mem_address;
            end
            if (a_if.mem_data_oe) cnt_oe++;
            if (port ? a_if.done1 : a_if.done0) begin
                cnt_done++;
                hold_rdata = port ? a_if.rdata1 : a_if.rdata0;
                set_req_a(port, 1'b0);
            end
            if (i == 0) begin
                if (port) begin
                    a_if.addr1 = ~addr; a_if.wdata1 = ~wdata;
                end else begin
                    a_if.addr0 = ~addr; a_if.wdata0 = ~wdata;
                end
                if (drop_early) set_req_a(port, 1'b0);
            end
        end
    endtask

    initial begin
        logic [3:0] order;
        int         starts [4];
        int         ng;
        int         both;
        logic       prev_g;
        logic       found;
        int         k;
        logic [3:0] rd_last;

        nrst = 1'b0;
        a_if.req0 = 0; a_if.req1 = 0; a_if.we0 = 0; a_if.we1 = 0;
        a_if.addr0 = 0; a_if.addr1 = 0; a_if.wdata0 = 0; a_if.wdata1 = 0;
        b_if.req0 = 0; b_if.req1 = 0; b_if.we0 = 0; b_if.we1 = 0;
        b_if.addr0 = 0; b_if.addr1 = 0; b_if.wdata0 = 0; b_if.wdata1 = 0;
        b_if.mem_data_in = 4'd0;
        tick();
        tick();
        check("rst_ctrl", 16'({a_if.gnt0, a_if.gnt1, a_if.done0, a_if.done1,
                               a_if.mem_nwrite_enable, a_if.mem_nread_enable, a_if.mem_data_oe}),
              16'b0000110);
        check("rst_data", {a_if.rdata0, a_if.rdata1, a_if.mem_address, a_if.mem_data_out}, 16'h0000);
        check("rst_state", 16'({a_state, b_state}), 16'd0);
        nrst = 1'b1;
        tick();

        // Port 0 write 0xA to address 5.
        run_a(1'b0, 1'b1, 4'd5, 4'hA, 1'b0);
        check("wr_gnt_cycles", cnt_gnt, 16'd3);
        check("wr_other_gnt", cnt_other, 16'd0);
        check("wr_nwe_cycles", cnt_nwe, 16'd1);
        check("wr_nre_cycles", cnt_nre, 16'd0);
        check("wr_oe_cycles", cnt_oe, 16'd3);
        check("wr_done", cnt_done, 16'd1);
        check("wr_strobe_addr", 16'(st_addr), 16'd5);
        check("wr_strobe_data", 16'(st_data), 16'hA);
        check("idle_addr_hold", 16'(a_if.mem_address), 16'd5);
        check("mem_written", 16'(mem_a[5]), 16'hA);

        // Port 1 read of address 5.
        run_a(1'b1, 1'b0, 4'd5, 4'h0, 1'b0);
        check("rd1_nre_cycles", cnt_nre, 16'd1);
        check("rd1_nwe_cycles", cnt_nwe, 16'd0);
        check("rd1_oe_cycles", cnt_oe, 16'd0);
        check("rd1_gnt_cycles", cnt_gnt, 16'd3);
        check("rd1_strobe_addr", 16'(st_addr), 16'd5);
        check("rd1_hold_rdata", 16'(hold_rdata), 16'hA);
        check("rd1_rdata0_kept", 16'(a_if.rdata0), 16'h0);

        run_a(1'b0, 1'b0, 4'd5, 4'h0, 1'b0);
        check("rd0_hold_rdata", 16'(hold_rdata), 16'hA);

        // A write by port 1 leaves both read registers alone.
        run_a(1'b1, 1'b1, 4'd5, 4'h3, 1'b0);
        check("wr1_done", cnt_done, 16'd1);
        check("wr1_rdata_kept", 16'({a_if.rdata0, a_if.rdata1}), 16'hAA);

        // Request dropped during SETUP still completes.
        run_a(1'b1, 1'b0, 4'd5, 4'h0, 1'b1);
        check("drop_done", cnt_done, 16'd1);
        check("drop_nre_cycles", cnt_nre, 16'd1);
        check("drop_rdata1", 16'(hold_rdata), 16'h3);
        check("drop_rdata0_kept", 16'(a_if.rdata0), 16'hA);

        // Both ports held high: last grant went to port 1, so order is 0,1,0,1.
        a_if.we0 = 0; a_if.we1 = 0; a_if.addr0 = 4'd1; a_if.addr1 = 4'd2;
        a_if.req0 = 1; a_if.req1 = 1;
        order = 4'd0; ng = 0; both = 0; prev_g = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (a_if.gnt0 && a_if.gnt1) both++;
            if ((a_if.gnt0 || a_if.gnt1) && !prev_g) begin
                order = {order[2:0], a_if.gnt1};
                if (ng < 4) starts[ng] = i;
                ng++;
            end
            prev_g = a_if.gnt0 || a_if.gnt1;
            if ((a_if.done0 || a_if.done1) && ng == 4) begin
                a_if.req0 = 0; a_if.req1 = 0;
            end
        end
        a_if.req0 = 0; a_if.req1 = 0;
        check("rr_grants", 16'(ng), 16'd4);
        check("rr_order", 16'(order), 16'b0101);
        check("rr_both_gnt", 16'(both), 16'd0);
        check("rr_period", 16'({4'(starts[1] - starts[0]), 4'(starts[2] - starts[1]),
                                4'(starts[3] - starts[2])}), 16'h444);

        // Reset pulled low while a write strobe is active.
        a_if.we0 = 1; a_if.addr0 = 4'd9; a_if.wdata0 = 4'hF; a_if.req0 = 1;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick();
            if (!a_if.mem_nwrite_enable) found = 1'b1;
        end
        check("rst_strobe_seen", 16'(found), 16'd1);
        nrst = 1'b0;
        tick();
        check("rst_mid_ctrl", 16'({a_if.gnt0, a_if.gnt1, a_if.done0, a_if.done1,
                                   a_if.mem_nwrite_enable, a_if.mem_nread_enable, a_if.mem_data_oe}),
              16'b0000110);
        check("rst_mid_state", 16'(a_state), 16'd0);
        nrst = 1'b1;
        tick();
        check("restart_setup", 16'({a_state, a_if.gnt0, a_if.mem_data_oe}), 16'b0111);
        cnt_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_if.done0) begin
                cnt_done++;
                a_if.req0 = 0;
            end
        end
        a_if.req0 = 0;
        check("restart_done", cnt_done, 16'd1);

        // Instance B: three-cycle read strobe; the bus changes each strobe cycle.
        b_if.we0 = 0; b_if.addr0 = 4'd6; b_if.req0 = 1;
        cnt_gnt = 0; cnt_nre = 0; cnt_nwe = 0; cnt_oe = 0; cnt_done = 0;
        k = 0; rd_last = 4'hF; hold_rdata = 4'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b_if.gnt0) cnt_gnt++;
            if (!b_if.mem_nwrite_enable) cnt_nwe++;
            if (b_if.mem_data_oe) cnt_oe++;
            if (!b_if.mem_nread_enable) begin
                cnt_nre++;
                k++;
                if (k == 3) rd_last = b_if.rdata0;
                b_if.mem_data_in = (k == 3) ? 4'hC : 4'(k);
            end else begin
                b_if.mem_data_in = 4'd0;
            end
            if (b_if.done0) begin
                cnt_done++;
                hold_rdata = b_if.rdata0;
                b_if.req0 = 0;
            end
        end
        b_if.req0 = 0;
        check("b_nre_cycles", cnt_nre, 16'd3);
        check("b_access_len", cnt_gnt, 16'd5);
        check("b_nwe_oe", 16'({cnt_nwe[7:0], cnt_oe[7:0]}), 16'h0000);
        check("b_done", cnt_done, 16'd1);
        check("b_rdata_in_strobe", 16'(rd_last), 16'h0);
        check("b_rdata_hold", 16'(hold_rdata), 16'hC);

        check("strobe_exclusive", 16'(n_excl), 16'd0);
        check("oe_during_read", 16'(n_oe_rd), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
